// File: rtl/ndma_read_mgr.sv
// Single-outstanding OBI read manager: accepts read commands, issues them on the
// bus one at a time and buffers returned words in a small FIFO for the consumer.
module ndma_read_mgr #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        ack_o,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic        read_mgr_req,
  output logic [31:0] read_mgr_addr,
  output logic        read_mgr_we,
  output logic [3:0]  read_mgr_be,
  output logic [31:0] read_mgr_wdata,
  input  logic        read_mgr_gnt,
  input  logic        read_mgr_rvalid,
  input  logic [31:0] read_mgr_rdata,
  input  logic        read_mgr_err,
  output logic [1:0]  state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  // Handshakes: a command transfers when req_i & ack_o; a word leaves the FIFO
  // when valid_o & ready_i; the bus request phase ends on read_mgr_req & gnt.
  logic [1:0]    state;
  logic [31:0]   addr_q;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [CW:0]   fill_after;

  assign push = (state == DATA) && read_mgr_rvalid;
  assign pop  = valid_o && ready_i;

  // Occupancy once the in-flight response lands, accounting for a same-cycle pop.
  assign fill_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

  always_comb begin
    ack_o = 1'b0;
    if (state == IDLE)
      ack_o = req_i && (count < CW'(DEPTH));
    else if (state == DATA)
      ack_o = read_mgr_rvalid && req_i && (fill_after < (CW+1)'(DEPTH));
  end

  assign read_mgr_req   = (state == ADDR);
  assign read_mgr_addr  = addr_q;
  assign read_mgr_we    = 1'b0;
  assign read_mgr_be    = 4'hF;
  assign read_mgr_wdata = 32'h0;

  assign data_o  = mem[rptr];
  assign valid_o = (count != '0);
  assign busy_o  = (state != IDLE) || (count != '0);
  assign state_o = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      addr_q <= 32'h0;
    end else begin
      if (ack_o)
        addr_q <= addr_i;
      case (state)
        IDLE:    if (ack_o) state <= ADDR;
        ADDR:    if (read_mgr_gnt) state <= DATA;
        DATA:    if (read_mgr_rvalid) state <= ack_o ? ADDR : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 32'h0;
    end else begin
      if (push) begin
        mem[wptr] <= read_mgr_rdata;
        wptr      <= wptr + PW'(1);
      end
      if (pop)
        rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear so a fresh error is never lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      err_o <= 1'b0;
    else if (push && read_mgr_err)
      err_o <= 1'b1;
    else if (err_clr_i)
      err_o <= 1'b0;
  end

endmodule

// File: tb/tb_ndma_read_mgr.sv
// Directed bench for ndma_read_mgr (DEPTH=2): bus responses are driven by hand
// and every expectation is a hand-computed constant.
module tb_ndma_read_mgr;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic        ack_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        busy_o;
  logic        err_o;
  logic        err_clr_i = 1'b0;
  logic        read_mgr_req;
  logic [31:0] read_mgr_addr;
  logic        read_mgr_we;
  logic [3:0]  read_mgr_be;
  logic [31:0] read_mgr_wdata;
  logic        read_mgr_gnt = 1'b0;
  logic        read_mgr_rvalid = 1'b0;
  logic [31:0] read_mgr_rdata = 32'h0;
  logic        read_mgr_err = 1'b0;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  ndma_read_mgr #(.DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .ack_o(ack_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
    .err_o(err_o), .err_clr_i(err_clr_i), .read_mgr_req(read_mgr_req),
    .read_mgr_addr(read_mgr_addr), .read_mgr_we(read_mgr_we),
    .read_mgr_be(read_mgr_be), .read_mgr_wdata(read_mgr_wdata),
    .read_mgr_gnt(read_mgr_gnt), .read_mgr_rvalid(read_mgr_rvalid),
    .read_mgr_rdata(read_mgr_rdata), .read_mgr_err(read_mgr_err), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // Move to 1 ns after the next rising edge; inputs are changed there and
  // outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    tick();
    #1;
    checks++;
    if ({ack_o, valid_o, busy_o, err_o, read_mgr_req, state_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags ack=%b valid=%b busy=%b err=%b req=%b state=%0d expected all 0",
               ack_o, valid_o, busy_o, err_o, read_mgr_req, state_o);
    end
    checks++;
    if (data_o !== 32'h0 || read_mgr_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_data data=%h addr=%h expected 0/0", data_o, read_mgr_addr);
    end
    checks++;
    if (read_mgr_we !== 1'b0 || read_mgr_be !== 4'hF || read_mgr_wdata !== 32'h0) begin
      errors++;
      $display("FAIL bus_constants we=%b be=%h wdata=%h expected 0/F/0",
               read_mgr_we, read_mgr_be, read_mgr_wdata);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    tick();
    req_i = 1'b1; addr_i = 32'h1000;
    #1;
    checks++;
    if (ack_o !== 1'b1 || read_mgr_req !== 1'b0) begin
      errors++;
      $display("FAIL single_ack ack=%b req=%b expected 1/0", ack_o, read_mgr_req);
    end
    tick();
    req_i = 1'b0; read_mgr_gnt = 1'b1;
    #1;
    checks++;
    if (read_mgr_req !== 1'b1 || read_mgr_addr !== 32'h1000 || ack_o !== 1'b0) begin
      errors++;
      $display("FAIL single_req req=%b addr=%h ack=%b expected 1/00001000/0",
               read_mgr_req, read_mgr_addr, ack_o);
    end
    tick();
    read_mgr_gnt = 1'b0;
    #1;
    checks++;
    if (read_mgr_req !== 1'b0 || state_o !== 2'd2 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_data_wait req=%b state=%0d busy=%b expected 0/2/1",
               read_mgr_req, state_o, busy_o);
    end
    tick();
    read_mgr_rvalid = 1'b1; read_mgr_rdata = 32'hDEADBEEF;
    tick();
    read_mgr_rvalid = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b1 || data_o !== 32'hDEADBEEF || state_o !== 2'd0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_data valid=%b data=%h state=%0d busy=%b expected 1/deadbeef/0/1",
               valid_o, data_o, state_o, busy_o);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_pop valid=%b busy=%b expected 0/0", valid_o, busy_o);
    end
  endtask

  task automatic test_gnt_stall();
    int bad;
    tick();
    req_i = 1'b1; addr_i = 32'h2000;
    #1;
    checks++;
    if (ack_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_ack ack=%b expected 1", ack_o);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      req_i = 1'b0; addr_i = 32'hFFFF_0000;
      #1;
      if (read_mgr_req !== 1'b1 || read_mgr_addr !== 32'h2000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold unstable_cycles=%0d expected 0", bad);
    end
    read_mgr_gnt = 1'b1;
    tick();
    read_mgr_gnt = 1'b0;
    tick();
    read_mgr_rvalid = 1'b1; read_mgr_rdata = 32'h0000A5A5;
    tick();
    read_mgr_rvalid = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b1 || data_o !== 32'h0000A5A5) begin
      errors++;
      $display("FAIL stall_data valid=%b data=%h expected 1/0000a5a5", valid_o, data_o);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_one_push valid=%b expected 0", valid_o);
    end
    // A stray response in IDLE must not push, move state or flag an error.
    read_mgr_rvalid = 1'b1; read_mgr_rdata = 32'h5555; read_mgr_err = 1'b1;
    tick();
    read_mgr_rvalid = 1'b0; read_mgr_err = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || state_o !== 2'd0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_rvalid valid=%b state=%0d err=%b expected 0/0/0", valid_o, state_o, err_o);
    end
  endtask

  task automatic test_back_pressure();
    tick();
    req_i = 1'b1; addr_i = 32'h3000;
    tick();
    read_mgr_gnt = 1'b1;
    #1;
    checks++;
    if (ack_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_addr_ack ack=%b expected 0", ack_o);
    end
    tick();
    read_mgr_gnt = 1'b0; read_mgr_rvalid = 1'b1; read_mgr_rdata = 32'h11;
    #1;
    checks++;
    if (ack_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_b2b ack=%b expected 1", ack_o);
    end
    tick();
    read_mgr_rvalid = 1'b0; read_mgr_gnt = 1'b1;
    tick();
    read_mgr_gnt = 1'b0; read_mgr_rvalid = 1'b1; read_mgr_rdata = 32'h22;
    #1;
    checks++;
    if (ack_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_data ack=%b expected 0", ack_o);
    end
    tick();
    read_mgr_rvalid = 1'b0;
    #1;
    checks++;
    if (ack_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 32'h11 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL bp_full_idle ack=%b valid=%b data=%h state=%0d expected 0/1/00000011/0",
               ack_o, valid_o, data_o, state_o);
    end
    tick();
    ready_i = 1'b1;
    #1;
    checks++;
    if (ack_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_pop_cycle ack=%b expected 0", ack_o);
    end
    tick();
    ready_i = 1'b0;
    #1;
    checks++;
    if (ack_o !== 1'b1 || data_o !== 32'h22) begin
      errors++;
      $display("FAIL bp_after_pop ack=%b data=%h expected 1/00000022", ack_o, data_o);
    end
    tick();
    req_i = 1'b0; read_mgr_gnt = 1'b1;
    tick();
    read_mgr_gnt = 1'b0; read_mgr_rvalid = 1'b1; read_mgr_rdata = 32'h33;
    tick();
    read_mgr_rvalid = 1'b0; ready_i = 1'b1;
    #1;
    checks++;
    if (data_o !== 32'h22 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_order0 data=%h valid=%b expected 00000022/1", data_o, valid_o);
    end
    tick();
    #1;
    checks++;
    if (data_o !== 32'h33 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_order1 data=%h valid=%b expected 00000033/1", data_o, valid_o);
    end
    tick();
    ready_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain valid=%b busy=%b expected 0/0", valid_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    ready_i = 1'b1; req_i = 1'b1; addr_i = 32'h4000;
    tick();
    read_mgr_gnt = 1'b1;
    tick();
    read_mgr_gnt = 1'b0; read_mgr_rvalid = 1'b1; read_mgr_rdata = 32'h44;
    #1;
    checks++;
    if (ack_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack ack=%b expected 1", ack_o);
    end
    tick();
    read_mgr_rvalid = 1'b0; read_mgr_gnt = 1'b1;
    #1;
    checks++;
    if (read_mgr_req !== 1'b1 || state_o !== 2'd1 || valid_o !== 1'b1 || data_o !== 32'h44) begin
      errors++;
      $display("FAIL b2b_reissue req=%b state=%0d valid=%b data=%h expected 1/1/1/00000044",
               read_mgr_req, state_o, valid_o, data_o);
    end
    tick();
    read_mgr_gnt = 1'b0; req_i = 1'b0; read_mgr_rvalid = 1'b1; read_mgr_rdata = 32'h55;
    #1;
    checks++;
    if (ack_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last ack=%b valid=%b expected 0/0", ack_o, valid_o);
    end
    tick();
    read_mgr_rvalid = 1'b0;
    #1;
    checks++;
    if (state_o !== 2'd0 || data_o !== 32'h55 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end state=%0d data=%h valid=%b expected 0/00000055/1", state_o, data_o, valid_o);
    end
    tick();
    ready_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_error();
    tick();
    req_i = 1'b1; addr_i = 32'h5000;
    tick();
    req_i = 1'b0; read_mgr_gnt = 1'b1;
    tick();
    read_mgr_gnt = 1'b0; read_mgr_rvalid = 1'b1; read_mgr_err = 1'b1; read_mgr_rdata = 32'h12345678;
    tick();
    read_mgr_rvalid = 1'b0; read_mgr_err = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b1 || valid_o !== 1'b1 || data_o !== 32'h12345678) begin
      errors++;
      $display("FAIL err_push err=%b valid=%b data=%h expected 1/1/12345678", err_o, valid_o, data_o);
    end
    tick();
    req_i = 1'b1; addr_i = 32'h5004;
    #1;
    checks++;
    if (err_o !== 1'b1 || ack_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky err=%b ack=%b expected 1/1", err_o, ack_o);
    end
    tick();
    req_i = 1'b0; read_mgr_gnt = 1'b1;
    tick();
    read_mgr_gnt = 1'b0; read_mgr_rvalid = 1'b1; read_mgr_err = 1'b1;
    read_mgr_rdata = 32'h9; err_clr_i = 1'b1;
    tick();
    read_mgr_rvalid = 1'b0; read_mgr_err = 1'b0; err_clr_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_set_wins err=%b expected 1", err_o);
    end
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clear err=%b expected 0", err_o);
    end
    ready_i = 1'b1;
    tick();
    #1;
    checks++;
    if (data_o !== 32'h9 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL err_second_word data=%h valid=%b expected 00000009/1", data_o, valid_o);
    end
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_reset_in_data();
    tick();
    req_i = 1'b1; addr_i = 32'h6000;
    tick();
    req_i = 1'b0; read_mgr_gnt = 1'b1;
    tick();
    read_mgr_gnt = 1'b0;
    #1;
    checks++;
    if (state_o !== 2'd2) begin
      errors++;
      $display("FAIL rst_pre_state state=%0d expected 2", state_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (state_o !== 2'd0 || busy_o !== 1'b0 || read_mgr_addr !== 32'h0 || read_mgr_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_async state=%0d busy=%b addr=%h req=%b expected 0/0/0/0",
               state_o, busy_o, read_mgr_addr, read_mgr_req);
    end
    tick();
    rst_i = 1'b0;
    tick();
    read_mgr_rvalid = 1'b1; read_mgr_rdata = 32'h77;
    tick();
    read_mgr_rvalid = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || state_o !== 2'd0 || busy_o !== 1'b0 || data_o !== 32'h0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_rvalid valid=%b state=%0d busy=%b data=%h err=%b expected 0/0/0/0/0",
               valid_o, state_o, busy_o, data_o, err_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gnt_stall();
    test_back_pressure();
    test_back_to_back();
    test_error();
    test_reset_in_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
